rsa_modexp_unit: RTL and testbench
==================================

Name: rsa_modexp_unit

Overview:
Parametrised successor to the fixed 8-bit RSA datapath. It computes C = P^E mod M using right-to-left binary exponentiation over two parallel bit-serial Montgomery multipliers (square and multiply lanes).
- Adds a start/busy/done handshake, an independent exponent width, early termination at the exponent MSB, and operand validity checking.
- Sits between the register/SPI front-end and the result register.

Parameters:
- WIDTH, 8, bit width of P, M, Const and C.
- EXP_WIDTH, WIDTH, bit width of E.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  clock enable; when 0, all state, counters and outputs hold
- start  in  1  request; sampled only in IDLE with en=1
- P  in  WIDTH  message/base, must be < M
- E  in  EXP_WIDTH  exponent
- M  in  WIDTH  modulus, odd, ≥ 3
- Const  in  WIDTH  R^2 mod M, where R = 2^N and N = WIDTH+2
- C  out  WIDTH  result, held until the next accepted start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at completion
- err  out  1  valid with done; 1 = operands rejected

Behaviour:
- Reset (rst=1 at a clk edge with en=1, or any edge regardless of en):
  - FSM returns to IDLE.
  - C, busy, done, err = 0.
  - All internal accumulators are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- Start acceptance: at the edge where state=IDLE, en=1, start=1, the block latches P, E, M, Const.
  - start while busy is ignored; the latched operands do not change.
- Validation at acceptance: if M[0]=0 or M<3, then next cycle done=1, err=1, C=0, and the FSM stays in IDLE. busy never rises.
- MMM op: radix-2 bit-serial MMM(A,B) = A·B·R^-1 mod M.
  - Timing: 1 clear cycle, then N iteration cycles, so N+1 cycles per op.
  - Iteration over i=0..N-1: t = S + A[i]·B; q = t[0]; S = (t + q·M) >> 1.
  - S width is WIDTH+3.
  - No intermediate subtraction: 4M < R guarantees S < 2M for inputs < 2M.
- FSM states: IDLE → PRE → LOOP → POST → IDLE.
  - PRE (1 op, both lanes in parallel):
    - Sq = MMM(P, Const)
    - Acc = MMM(1, Const)
  - LOOP: bit index j starts at 0, k = (position of highest set bit of E) + 1.
    - If k = 0, skip LOOP.
    - Per op, run in parallel: Acc = E[j] ? MMM(Acc, Sq) : Acc; Sq = MMM(Sq, Sq).
    - The multiply lane idles but still consumes the N+1 cycles.
    - j increments; exit when j = k.
  - POST (1 op): T = MMM(Acc, 1); C = (T ≥ M) ? T−M : T, truncated to WIDTH.
- Latency: done asserts L = (k+2)·(N+1) edges after the start edge (en held 1); en=0 cycles add 1:1.
  - busy falls in the same cycle done rises.
  - err=0.
  - C updates in the same cycle as done.
- Boundaries:
  - E=0 gives C=1.
  - P=0 with E>0 gives C=0.
  - P ≥ M or a wrong Const is not detected; the result is undefined but the handshake timing is unchanged.
  - start on the same edge as rst: rst wins.

Test Plan:
1. WIDTH=8, M=187, Const=67, P=88, E=7, start 1 cycle → done at edge 56, C=11, err=0; busy high for exactly 55 cycles.
2. Same operands but P=11, E=23 (k=5) → done at edge 78, C=88; reassert start while busy at cycle 10 → ignored, single done.
3. E=0, P=88, M=187, Const=67 → done at edge 23, C=1; then P=0, E=5 → C=0, done at edge 56.
4. M=186 → done=1, err=1 at edge 1, C=0, busy stays 0; then M=3, Const=1, P=2, E=3 → C=2.
5. Scenario 1 with en toggled 0 for 7 random cycles mid-LOOP → done at edge 63, C=11; rst=1 at cycle 30 of a second run → no done, all outputs 0, next start runs normally.
6. Random sweep with WIDTH=16, EXP_WIDTH=17 on odd M ≥ 3: software reference pow(P,E,M) with Const=2^36 mod M → C matches, latency matches (k+2)·19.

Source files
------------

// File: rtl/rsa_modexp_unit.sv
// rsa_modexp_unit: C = P^E mod M by right-to-left binary exponentiation on two bit-serial Montgomery lanes; start/busy/done/err handshake
module rsa_modexp_unit #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [WIDTH-1:0]     P,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Const,
  output logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int N  = WIDTH + 2;
  localparam int SW = WIDTH + 3;
  localparam int CW = $clog2(N + 1);
  localparam int KW = $clog2(EXP_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, PRE, LOOP, POST} state_t;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [KW-1:0]        j, k;
  logic [WIDTH-1:0]     p_r, m_r, const_r, c_fin;
  logic [EXP_WIDTH-1:0] e_r;
  logic [SW-1:0]        sq, acc, s_sq, s_mul, nxt_sq, nxt_mul;
  logic [SW-1:0]        a_sq, b_sq, a_mul, b_mul, m_x;
  logic                 last, e_bit;
  function automatic logic [SW-1:0] mmm_step(input logic [SW-1:0] s, a, b, m, input logic [CW-1:0] i);
    logic [SW-1:0] t;
    t = s + (|(a & (SW'(1) << i)) ? b : '0);
    t = t + (t[0] ? m : '0);
    return t >> 1;
  endfunction
  always_comb begin
    k = '0;
    for (int i = 0; i < EXP_WIDTH; i++)
      if (e_r[i]) k = KW'(i + 1);
  end
  assign m_x     = SW'(m_r);
  assign a_sq    = state == PRE ? SW'(p_r) : sq;
  assign b_sq    = state == PRE ? SW'(const_r) : sq;
  assign a_mul   = state == PRE ? SW'(1) : acc;
  assign b_mul   = state == PRE ? SW'(const_r) : state == LOOP ? sq : SW'(1);
  assign nxt_sq  = mmm_step(s_sq, a_sq, b_sq, m_x, cnt - 1'b1);
  assign nxt_mul = mmm_step(s_mul, a_mul, b_mul, m_x, cnt - 1'b1);
  assign c_fin   = WIDTH'(nxt_mul >= m_x ? nxt_mul - m_x : nxt_mul);
  assign last    = cnt == CW'(N);
  assign e_bit   = |(e_r & (EXP_WIDTH'(1) << j));
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      j       <= '0;
      p_r     <= '0;
      e_r     <= '0;
      m_r     <= '0;
      const_r <= '0;
      sq      <= '0;
      acc     <= '0;
      s_sq    <= '0;
      s_mul   <= '0;
      C       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          p_r     <= P;
          e_r     <= E;
          m_r     <= M;
          const_r <= Const;
          cnt     <= '0;
          j       <= '0;
          if (!M[0] || M < WIDTH'(3)) begin
            done <= 1'b1;
            err  <= 1'b1;
            C    <= '0;
          end else begin
            state <= PRE;
            busy  <= 1'b1;
          end
        end
      end else begin
        cnt   <= last ? '0 : cnt + 1'b1;
        s_sq  <= cnt == '0 ? '0 : nxt_sq;
        s_mul <= cnt == '0 ? '0 : nxt_mul;
        if (last) begin
          if (state == PRE) begin
            sq    <= nxt_sq;
            acc   <= nxt_mul;
            state <= k == '0 ? POST : LOOP;
          end else if (state == LOOP) begin
            sq  <= nxt_sq;
            acc <= e_bit ? nxt_mul : acc;
            j   <= j + 1'b1;
            if (j + 1'b1 == k) state <= POST;
          end else begin
            C     <= c_fin;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rsa_modexp_unit.sv
// tb_rsa_modexp_unit: scoreboard bench for rsa_modexp_unit with directed vectors
module tb_rsa_modexp_unit;
  localparam int W = 8;
  localparam int EW = 8;
  localparam int NP1 = W + 3;
  typedef struct {
    logic [W-1:0] c;
    logic         err;
    int           en_at;
    int           busy_at;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0;
  logic [W-1:0] p = '0, m = '0, cst = '0, c;
  logic [EW-1:0] e = '0;
  logic busy, done, err;
  exp_t q[$];
  int en_edges = 0, busy_en = 0, n_cmp = 0, n_err = 0;
  rsa_modexp_unit #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .P(p), .E(e), .M(m), .Const(cst),
    .C(c), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (en) begin
      en_edges++;
      if (busy) busy_en++;
    end
  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask
  always @(negedge clk)
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with C=%0d, expected no done", c);
      end else begin
        exp_t x;
        x = q.pop_front();
        check("result_c", 32'(c), 32'(x.c));
        check("err_flag", 32'(err), 32'(x.err));
        check("latency_en_edges", en_edges, x.en_at);
        check("busy_cycles", busy_en, x.busy_at);
      end
    end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  function automatic int kbits(int ev);
    int k = 0;
    for (int i = 0; i < EW; i++) if (ev[i]) k = i + 1;
    return k;
  endfunction
  function automatic int modpow(int b, int ex, int mm);
    longint r = 1, bb = longint'(b % mm);
    for (int i = 0; i < EW; i++) begin
      if (ex[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return int'(r);
  endfunction
  task automatic issue(int pp, int ee, int mm, int cc, int exp_c, bit bad);
    exp_t x;
    int lat;
    lat = bad ? 0 : (kbits(ee) + 2) * NP1;
    p = W'(pp);
    e = EW'(ee);
    m = W'(mm);
    cst = W'(cc);
    x.c = W'(exp_c);
    x.err = bad;
    x.en_at = en_edges + 1 + lat;
    x.busy_at = busy_en + lat;
    q.push_back(x);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic wait_done;
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      tick;
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
      q.delete();
    end
  endtask
  initial begin
    repeat (3) tick;
    check("reset_c", 32'(c), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    rst = 1'b0;
    tick;
    issue(88, 7, 187, 67, 11, 0);
    wait_done;
    repeat (5) tick;
    check("c_hold", 32'(c), 11);
    issue(11, 23, 187, 67, 88, 0);
    repeat (9) tick;
    p = 8'd5;
    e = 8'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done;
    issue(88, 0, 187, 67, 1, 0);
    wait_done;
    issue(0, 5, 187, 67, 0, 0);
    wait_done;
    issue(88, 7, 186, 67, 0, 1);
    wait_done;
    check("busy_after_reject", 32'(busy), 0);
    issue(0, 3, 1, 0, 0, 1);
    wait_done;
    issue(2, 3, 3, 1, 2, 0);
    wait_done;
    issue(88, 7, 187, 67, 11, 0);
    repeat (20) tick;
    en = 1'b0;
    repeat (7) tick;
    check("busy_hold_en0", 32'(busy), 1);
    en = 1'b1;
    wait_done;
    issue(88, 7, 187, 67, 11, 0);
    repeat (29) tick;
    rst = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    q.delete();
    check("midrst_c", 32'(c), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (3) tick;
    check("no_start_with_rst", 32'(busy), 0);
    issue(11, 23, 187, 67, 88, 0);
    wait_done;
    for (int n = 0; n < 6; n++) begin
      int mm, pp, ee;
      mm = int'($urandom_range(1, 127)) * 2 + 1;
      pp = int'($urandom_range(0, mm - 1));
      ee = int'($urandom_range(0, 255));
      issue(pp, ee, mm, (1 << 20) % mm, modpow(pp, ee, mm), 0);
      wait_done;
    end
    repeat (3) tick;
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
